// File: rtl/cic_decim.sv
// Dual-channel I/Q CIC decimator: STAGES integrators at clock rate, STAGES combs at clk/RATE, round-half-up to OUT_W.
// Output strobe STAGES+1 clocks after the sample edge; no backpressure, a new input sample is taken every clock.
module cic_decim #(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 24,
  parameter int STAGES = 3,
  parameter int RATE   = 40,
  parameter int ACC_W  = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  i_in,
  input  logic signed [IN_W-1:0]  q_in,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    out_valid
);
  localparam int CNT_W = $clog2(RATE);
  localparam int SHIFT = ACC_W - OUT_W;
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic [CNT_W-1:0]        cnt;
  logic                    sample;
  logic [STAGES:0]         ph;
  logic signed [ACC_W-1:0] x_ext [2];
  logic signed [ACC_W-1:0] integ [2][STAGES];
  logic signed [ACC_W-1:0] comb  [2][STAGES+1];
  logic signed [ACC_W-1:0] dly   [2][STAGES];
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic [OUT_W-1:0]        trunc   [2];
  logic [OUT_W-1:0]        rounded [2];
  logic [1:0]              rbit;

  assign sample = (cnt == CNT_W'(RATE - 1));
  assign acc_i  = comb[0][STAGES];
  assign acc_q  = comb[1][STAGES];

  always_comb begin
    x_ext[0] = {{(ACC_W-IN_W){i_in[IN_W-1]}}, i_in};
    x_ext[1] = {{(ACC_W-IN_W){q_in[IN_W-1]}}, q_in};
  end

  // Round half up; only the positive maximum can overflow, so clamp it there.
  always_comb begin
    trunc[0] = OUT_W'(acc_i >>> SHIFT);
    trunc[1] = OUT_W'(acc_q >>> SHIFT);
    rbit[0]  = acc_i[SHIFT-1];
    rbit[1]  = acc_q[SHIFT-1];
    for (int ch = 0; ch < 2; ch++) begin
      if (trunc[ch] == POS_MAX && rbit[ch]) rounded[ch] = POS_MAX;
      else                                  rounded[ch] = trunc[ch] + OUT_W'(rbit[ch]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      ph        <= '0;
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        for (int k = 0; k < STAGES; k++) begin
          integ[ch][k] <= '0;
          dly[ch][k]   <= '0;
        end
        for (int k = 0; k <= STAGES; k++) comb[ch][k] <= '0;
      end
    end else begin
      cnt       <= sample ? '0 : cnt + 1'b1;
      // ph[k] marks the edge at which comb stage k+1 (or the output, k = STAGES) fires.
      ph        <= {ph[STAGES-1:0], sample};
      out_valid <= ph[STAGES];
      for (int ch = 0; ch < 2; ch++) begin
        integ[ch][0] <= integ[ch][0] + x_ext[ch];
        for (int k = 1; k < STAGES; k++) integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
        if (sample) comb[ch][0] <= integ[ch][STAGES-1];
        for (int k = 1; k <= STAGES; k++) begin
          if (ph[k-1]) begin
            comb[ch][k]  <= comb[ch][k-1] - dly[ch][k-1];
            dly[ch][k-1] <= comb[ch][k-1];
          end
        end
      end
      if (ph[STAGES]) begin
        i_out <= rounded[0];
        q_out <= rounded[1];
      end
    end
  end
endmodule

// File: tb/tb_cic_decim.sv
// Bench for cic_decim: direct-form FIR reference (boxcar^3) feeding an expected-output queue.
module tb_cic_decim;
  localparam int R  = 40;
  localparam int N  = 3;
  localparam int HL = N * (R - 1) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] i_in;
  logic signed [17:0] q_in;
  logic signed [23:0] i_out;
  logic signed [23:0] q_out;
  logic               out_valid;

  cic_decim dut (
    .clk      (clk),
    .rst      (rst),
    .i_in     (i_in),
    .q_in     (q_in),
    .i_out    (i_out),
    .q_out    (q_out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint ei;
    longint eq;
  } exp_t;

  exp_t   sb[$];
  longint h[HL];
  int     xi[$];
  int     xq[$];
  int     e;
  longint last_i;
  longint last_q;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, e);
    end
  endtask

  function automatic void build_h();
    longint t[HL];
    for (int k = 0; k < HL; k++) t[k] = (k < R) ? 1 : 0;
    repeat (N - 1) begin
      for (int k = 0; k < HL; k++) begin
        h[k] = 0;
        for (int j = 0; j < R && j <= k; j++) h[k] += t[k-j];
      end
      for (int k = 0; k < HL; k++) t[k] = h[k];
    end
  endfunction

  function automatic longint rnd(input longint s);
    logic [63:0] sv;
    logic [33:0] a;
    logic [23:0] t;
    sv = s;
    a  = sv[33:0];
    t  = a[33:10];
    if (t == 24'h7FFFFF && a[9]) return 64'sd8388607;
    t = t + {23'd0, a[9]};
    return longint'($signed(t));
  endfunction

  function automatic longint xv(input int idx, input bit qch);
    if (idx < 1 || idx > xi.size()) return 0;
    return qch ? xq[idx-1] : xi[idx-1];
  endfunction

  function automatic int r18();
    logic signed [17:0] r;
    r = 18'($urandom);
    return int'(r);
  endfunction

  function automatic void reset_model();
    e = 0;
    xi.delete();
    xq.delete();
    sb.delete();
    last_i = 0;
    last_q = 0;
  endfunction

  task automatic step(input int vi, input int vq);
    bit   live;
    bit   exp_v;
    exp_t t;
    i_in = 18'(vi);
    q_in = 18'(vq);
    live = rst;
    @(posedge clk);
    #1;
    if (live) begin
      e++;
      xi.push_back(vi);
      xq.push_back(vq);
      if (e % R == 0) begin
        longint si = 0;
        longint sq = 0;
        for (int k = 0; k < HL; k++) begin
          si += h[k] * xv(e - 3 - k, 1'b0);
          sq += h[k] * xv(e - 3 - k, 1'b1);
        end
        t.due = e + N + 1;
        t.ei  = rnd(si);
        t.eq  = rnd(sq);
        sb.push_back(t);
      end
      exp_v = (sb.size() > 0 && sb[0].due == e);
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
        t = sb.pop_front();
        last_i = t.ei;
        last_q = t.eq;
      end
      chk("i_out", i_out, last_i);
      chk("q_out", q_out, last_q);
    end else begin
      chk("rst_valid", out_valid, 0);
      chk("rst_i", i_out, 0);
      chk("rst_q", q_out, 0);
    end
  endtask

  // Steps until the next edge is an output edge; reports a failure if none comes.
  task automatic align_to_output(input int vi, input int vq);
    bit found;
    found = 0;
    for (int n = 0; n < 2 * R && !found; n++) begin
      if (sb.size() > 0 && sb[0].due == e + 1) found = 1;
      else step(vi, vq);
    end
    chk("align", found, 1);
  endtask

  initial begin
    exp_t t;
    build_h();
    reset_model();
    rst  = 1'b0;
    i_in = '0;
    q_in = '0;

    // Reset held with random inputs
    repeat (6) step(r18(), r18());
    rst = 1'b1;

    // DC: steady state 4096*62.5 = 256000
    repeat (400) step(4096, -4096);
    chk("dc_i_steady", i_out, 256000);
    chk("dc_q_steady", q_out, -256000);

    // Random full-range samples
    repeat (400) step(r18(), r18());

    // Full scale with integrator wrap
    repeat (10000) step(131071, -131072);
    chk("fs_i_steady", i_out, 8191938);
    chk("fs_q_steady", q_out, -8192000);

    // Impulse at cnt == 0
    repeat (240) step(0, 0);
    while (e % R != 0) step(0, 0);
    step(1024, 0);
    repeat (300) step(0, 0);

    // Odd DC: exact half LSB rounds up on both signs
    repeat (200) step(3, -3);
    chk("half_up_pos", i_out, 188);
    chk("half_up_neg", q_out, -187);

    // Forced accumulator: positive clamp and 0x1FF round-down
    align_to_output(3, -3);
    force dut.acc_i = 34'h1FFFFFE00;
    force dut.acc_q = 34'h048D159FF;
    t = sb.pop_front();
    t.ei = 8388607;
    t.eq = 24'h123456;
    sb.push_front(t);
    step(3, -3);
    release dut.acc_i;
    release dut.acc_q;
    align_to_output(3, -3);
    force dut.acc_i = 34'h200000200;
    force dut.acc_q = 34'h1FFFFFDFF;
    t = sb.pop_front();
    t.ei = -8388607;
    t.eq = 8388607;
    sb.push_front(t);
    step(3, -3);
    release dut.acc_i;
    release dut.acc_q;
    repeat (200) step(3, -3);

    // Mid-frame asynchronous reset
    repeat (90) step(4096, -4096);
    #3 rst = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_i", i_out, 0);
    chk("async_q", q_out, 0);
    reset_model();
    repeat (5) step(r18(), r18());
    rst = 1'b1;
    repeat (300) step(4096, -4096);
    chk("post_rst_i", i_out, 256000);
    chk("post_rst_q", q_out, -256000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cic_decim.md
# cic_decim

Dual-channel (I/Q) fixed-rate CIC decimator for the receive chain. Consumes the 18-bit signed I and Q samples the mixer produces every clock, decimates by RATE through a STAGES-order CIC, and emits rounded 24-bit I/Q words with a one-clock valid strobe. Downstream filtering (CFIR/FIR decimators, packetiser) consumes `out_valid`-qualified data.

## Interface
- `IN_W`, 18, input sample width (signed)
- `OUT_W`, 24, output sample width (signed)
- `STAGES`, 3, number of integrator and comb stages; differential delay M = 1
- `RATE`, 40, decimation ratio, 2..255
- `ACC_W`, 34, accumulator width = IN_W + ceil(STAGES·log2(RATE))
- `clk`  in  1  sample clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_in`  in  IN_W  signed I sample, new value every clock
- `q_in`  in  IN_W  signed Q sample, new value every clock
- `i_out`  out  OUT_W  signed decimated I
- `q_out`  out  OUT_W  signed decimated Q
- `out_valid`  out  1  one-clock strobe, i_out/q_out valid while high

## Operation
- Reset (rst low, async): all integrators, comb data/delay registers, decimation counter, `i_out`, `q_out`, `out_valid` cleared to 0. Reset during operation discards all state; behaviour after release is identical to power-up.
- Inputs are sign-extended to ACC_W. No input valid; every clock is a sample.
- Integrators: I1 <= I1 + in; Ik <= Ik + I(k-1), k = 2..STAGES; all registered, updated every clock. Two's-complement wrap-around is required and intended; no saturation in integrators or combs.
- Decimation counter `cnt`: 0..RATE-1, increments every clock, wraps to 0. Sample edge S = edge where cnt == RATE-1.
- At S: d0 <= I_STAGES. Comb k at edge S+k: ck <= c(k-1) − zk; zk <= c(k-1) (c0 = d0). Comb registers hold between sample edges.
- Output at edge S+STAGES+1: out = ACC[ACC_W-1 : ACC_W-OUT_W] + ACC[ACC_W-OUT_W-1] (round half up, ACC = c_STAGES). If the truncated value is 0x7FFFFF and the round bit is 1, output 0x7FFFFF (no wrap to negative). Same rule for I and Q.
- DC gain = RATE^STAGES / 2^(ACC_W-OUT_W) = 64000/1024 = 62.5 with defaults.
- I and Q paths are identical and cycle-aligned.

## Timing
- `out_valid` rises at edge S+STAGES+1, falls at the next edge; exactly one high cycle per RATE clocks.
- First S after reset release is the RATE-th rising edge (cnt 0→RATE-1); with defaults `out_valid` first rises at edge 44, then every 40 clocks.
- `i_out`/`q_out` hold their value until the next output edge.
- First STAGES output words after reset are startup transient; output STAGES+1 onward is steady-state.
- Input-to-output latency (last contributing sample to strobe): STAGES−1 integrator edges + STAGES+2 comb/output edges.

## Test plan
- Reset: hold rst low with random inputs → all outputs 0; release → first `out_valid` at edge 44, then period exactly 40 clocks, width 1 clock.
- DC: i_in = 4096, q_in = −4096 constant → from 4th output on, i_out = 256000, q_out = −256000.
- Full-scale: i_in = 131071, q_in = −131072 for ≥10000 clocks (integrators wrap many times) → i_out = 8191938, q_out = −8192000 every steady-state output, no glitches.
- Impulse: single i_in = 1024 at cnt==0, else 0 → i_out sequence matches reference CIC impulse response (sum of outputs = 1024·62.5·... per model), q_out stays 0.
- Rounding/saturation: force ACC to 0x7FFFFF·2^10 + 0x200 via comb preload (or equivalent stimulus) → i_out = 0x7FFFFF, not 0x800000; ACC LSB field 0x1FF → rounds down.
- Mid-operation reset: assert rst asynchronously (not clock-aligned) mid-frame → outputs clear immediately; after release, timing and DC values match the power-up case.
